// File: rtl/mem_responder.sv
// mem_responder: default on-chip RAM target answering the core's ifu/lsu
// reqValid/respValid handshake.
//
// One request is outstanding at a time. lsu wins when both ports request in
// the same cycle. Each accepted request gets exactly one single-cycle
// respValid pulse LATENCY cycles after the cycle it was sampled in. The
// array access (read, or byte-strobed write) happens on the clock edge that
// enters the response cycle, so the rdata registers and the array are
// updated together.
//
// Optional build macro:
//   MEM_RAND_DELAY_EN - a 16-bit LFSR (seed 16'hACE1, advances every cycle)
//                       adds lfsr[2:0] extra cycles to each request's latency.
//
// Ports:
//   clock, reset      - clock and asynchronous active-low reset
//   ifu_reqValid      - fetch request, held by the initiator until answered
//   ifu_addr          - fetch byte address
//   ifu_respValid     - one-cycle fetch response pulse
//   ifu_rdata         - fetch data, valid with ifu_respValid, held after
//   lsu_reqValid      - load/store request, held until answered
//   lsu_wen           - 1 = store, 0 = load
//   lsu_addr          - load/store byte address
//   lsu_wdata         - store data, lanes aligned to a word boundary
//   lsu_wmask         - store byte strobes
//   lsu_respValid     - one-cycle load/store response pulse
//   lsu_rdata         - load data, valid with lsu_respValid, held after
//   busy              - a request is outstanding
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        busy
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Wide enough for LATENCY-1 plus up to 7 random extra cycles.
  localparam int unsigned CntW = $clog2(LATENCY + 8);
  // Size of the window in bytes; 33 bits so BASE_ADDR + span never wraps.
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [CntW-1:0] LatLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Captured request.
  logic            cap_lsu_q, cap_lsu_d;
  logic            cap_wen_q, cap_wen_d;
  logic [31:0]     cap_addr_q, cap_addr_d;
  logic [31:0]     cap_wdata_q, cap_wdata_d;
  logic [3:0]      cap_wmask_q, cap_wmask_d;

  logic [31:0]     ifu_rdata_q, lsu_rdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept, acc_lsu;
  logic [2:0]      extra;
  logic [CntW-1:0] load_val;

  logic            enter_resp;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rd_word;
  logic            mem_we;

  // ---------------------------------------------------------------------
  // Extra latency source
  // ---------------------------------------------------------------------
`ifdef MEM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign extra = lfsr_q[2:0];
`else
  assign extra = 3'd0;
`endif

  assign load_val = LatLoad + CntW'(extra);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_lsu_d   = cap_lsu_q;
    cap_wen_d   = cap_wen_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_wmask_d = cap_wmask_q;
    accept      = 1'b0;
    acc_lsu     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsu_reqValid) begin
          accept  = 1'b1;
          acc_lsu = 1'b1;
        end else if (ifu_reqValid) begin
          accept  = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        // The port being answered still holds its (already served) request,
        // so only the other port may be accepted back-to-back.
        if (!cap_lsu_q && lsu_reqValid) begin
          accept  = 1'b1;
          acc_lsu = 1'b1;
        end else if (cap_lsu_q && ifu_reqValid) begin
          accept  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      cap_lsu_d   = acc_lsu;
      cap_wen_d   = acc_lsu & lsu_wen;
      cap_addr_d  = acc_lsu ? lsu_addr : ifu_addr;
      cap_wdata_d = acc_lsu ? lsu_wdata : 32'h0;
      cap_wmask_d = acc_lsu ? lsu_wmask : 4'h0;
      cnt_d       = load_val;
      state_d     = (load_val == '0) ? StResp : StWait;
    end
  end

  // ---------------------------------------------------------------------
  // Array access on the edge that enters StResp. The *_d capture holds the
  // request being answered whether it was just accepted (zero wait) or has
  // been waiting.
  // ---------------------------------------------------------------------
  assign enter_resp = (state_d == StResp);
  assign offset     = cap_addr_d - BASE_ADDR;
  assign in_range   = (cap_addr_d >= BASE_ADDR) && ({1'b0, offset} < SpanBytes);
  assign word_idx   = offset[IdxW+1:2];
  assign rd_word    = in_range ? mem_q[word_idx] : 32'h0;

  // Gated by reset so nothing lands in the array while reset is asserted.
  assign mem_we = enter_resp & cap_lsu_d & cap_wen_d & in_range & reset;

  // Array contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_wmask_d[i]) begin
          mem_q[word_idx][8*i +: 8] <= cap_wdata_d[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_lsu_q   <= 1'b0;
      cap_wen_q   <= 1'b0;
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
      cap_wmask_q <= 4'h0;
      ifu_rdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_lsu_q   <= cap_lsu_d;
      cap_wen_q   <= cap_wen_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_wmask_q <= cap_wmask_d;
      // Store responses leave lsu_rdata untouched.
      if (enter_resp && !cap_wen_d) begin
        if (cap_lsu_d) begin
          lsu_rdata_q <= rd_word;
        end else begin
          ifu_rdata_q <= rd_word;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ifu_respValid = (state_q == StResp) && !cap_lsu_q;
  assign lsu_respValid = (state_q == StResp) && cap_lsu_q;
  assign busy          = (state_q != StIdle);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a table of isolated transactions,
// hand-written multi-cycle sequences (arbitration, back-to-back, reset
// abort), then randomized traffic checked against a timeline model.
module tb_mem_responder;

  localparam logic [31:0] B  = 32'h8000_0000;
  localparam int unsigned DW = 4096;
  localparam int unsigned L  = 2;
  localparam int          NCYC = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = 32'h0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [3:0]  lsu_wmask = 4'h0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        busy;

  always #5 clock = ~clock;

  mem_responder #(
    .BASE_ADDR  (B),
    .DEPTH_WORDS(DW),
    .LATENCY    (L)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ifu_reqValid (ifu_reqValid),
    .ifu_addr     (ifu_addr),
    .ifu_respValid(ifu_respValid),
    .ifu_rdata    (ifu_rdata),
    .lsu_reqValid (lsu_reqValid),
    .lsu_wen      (lsu_wen),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_respValid(lsu_respValid),
    .lsu_rdata    (lsu_rdata),
    .busy         (busy)
  );

  typedef struct packed {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rd;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_ifu_rd = 32'h0;
  logic [31:0] exp_lsu_rd = 32'h0;
  logic [31:0] mm [int];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= B) && ((a - B) < 4 * DW);
  endfunction

  function automatic int wkey(input logic [31:0] a);
    return int'((a - B) >> 2);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] oor [4];
    oor[0] = B - 32'd4;
    oor[1] = B + 4 * DW;
    oor[2] = 32'h0;
    oor[3] = 32'hFFFF_FFFC;
    if ($urandom_range(0, 9) == 0) return oor[$urandom_range(0, 3)];
    return B + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  // One isolated transaction, entered at posedge+1 with the DUT idle.
  task automatic xact(input logic is_lsu, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask,
                      input logic [31:0] exp_rd, input string nm);
    int lat = 0;
    if (is_lsu) begin
      lsu_reqValid = 1'b1;
      lsu_wen      = wen;
      lsu_addr     = addr;
      lsu_wdata    = wdata;
      lsu_wmask    = wmask;
    end else begin
      ifu_reqValid = 1'b1;
      ifu_addr     = addr;
    end
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (k == 1) chk({nm, " busy"}, 32'(busy), 32'd1);
      if (is_lsu ? lsu_respValid : ifu_respValid) lat = k;
      chk({nm, " both_resp"}, 32'(ifu_respValid & lsu_respValid), 32'd0);
    end
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'(L));
    if (!is_lsu) exp_ifu_rd = exp_rd;
    else if (!wen) exp_lsu_rd = exp_rd;
    chk({nm, " lsu_rdata"}, lsu_rdata, exp_lsu_rd);
    chk({nm, " ifu_rdata"}, ifu_rdata, exp_ifu_rd);
    tick();
    chk({nm, " pulse_end"}, 32'(is_lsu ? lsu_respValid : ifu_respValid), 32'd0);
    chk({nm, " busy_end"}, 32'(busy), 32'd0);
  endtask

  // Two loads raised at given cycles; checks each response cycle and data.
  task automatic run_pair(input int ti, input int tl, input logic [31:0] ia,
                          input logic [31:0] la, input logic [31:0] ie,
                          input logic [31:0] le, input int eci, input int ecl,
                          input string nm);
    int ci = -1;
    int cl = -1;
    for (int c = 0; c < 14; c++) begin
      if (c == ti) begin
        ifu_reqValid = 1'b1;
        ifu_addr     = ia;
      end
      if (c == tl) begin
        lsu_reqValid = 1'b1;
        lsu_wen      = 1'b0;
        lsu_addr     = la;
      end
      if (ifu_respValid) begin
        if (ci < 0) ci = c;
        ifu_reqValid = 1'b0;
      end
      if (lsu_respValid) begin
        if (cl < 0) cl = c;
        lsu_reqValid = 1'b0;
      end
      chk({nm, " both_resp"}, 32'(ifu_respValid & lsu_respValid), 32'd0);
      tick();
    end
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    exp_ifu_rd = ie;
    exp_lsu_rd = le;
    chk({nm, " ifu_cycle"}, 32'(ci), 32'(eci));
    chk({nm, " lsu_cycle"}, 32'(cl), 32'(ecl));
    chk({nm, " ifu_rdata"}, ifu_rdata, ie);
    chk({nm, " lsu_rdata"}, lsu_rdata, le);
  endtask

  // Randomized traffic against a timeline model: at most one scheduled
  // response; accepting at cycle c schedules the answer at c+L.
  task automatic random_phase();
    bit          i_pend = 0, l_pend = 0, i_done = 0, l_done = 0;
    bit          sched = 0, resp_lsu = 0, resp_wen = 0;
    bit          e_ir, e_lr, tl, ti, at_resp;
    int          acc_c = 0, resp_c = 0;
    logic [31:0] resp_data = 32'h0;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      mm[i] = w;
      xact(1'b1, 1'b1, B + 32'(4 * i), w, 4'hF, 32'h0, "rnd_init");
    end
    for (int c = 0; c < NCYC + 40; c++) begin
      at_resp = sched && (resp_c == c);
      e_ir = at_resp && !resp_lsu;
      e_lr = at_resp && resp_lsu;
      if (e_ir) exp_ifu_rd = resp_data;
      if (e_lr && !resp_wen) exp_lsu_rd = resp_data;
      chk("rnd ifu_respValid", 32'(ifu_respValid), 32'(e_ir));
      chk("rnd lsu_respValid", 32'(lsu_respValid), 32'(e_lr));
      chk("rnd busy", 32'(busy), 32'(sched && c > acc_c && c <= resp_c));
      chk("rnd ifu_rdata", ifu_rdata, exp_ifu_rd);
      chk("rnd lsu_rdata", lsu_rdata, exp_lsu_rd);
      // Initiators: hold through the response cycle, drop the next cycle.
      if (i_done) begin ifu_reqValid = 1'b0; i_pend = 0; i_done = 0; end
      if (l_done) begin lsu_reqValid = 1'b0; l_pend = 0; l_done = 0; end
      if (e_ir) i_done = 1;
      if (e_lr) l_done = 1;
      if (!i_pend && c < NCYC && $urandom_range(0, 3) == 0) begin
        i_pend = 1;
        ifu_reqValid = 1'b1;
        ifu_addr = rand_addr();
      end
      if (!l_pend && c < NCYC && $urandom_range(0, 3) == 0) begin
        l_pend = 1;
        lsu_reqValid = 1'b1;
        lsu_wen = 1'($urandom_range(0, 1));
        lsu_addr = rand_addr();
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom_range(0, 15));
      end
      if (!sched || at_resp) begin
        tl = lsu_reqValid && !(at_resp && resp_lsu);
        ti = ifu_reqValid && !(at_resp && !resp_lsu);
        if (tl || ti) begin
          resp_lsu = tl;
          resp_wen = tl && lsu_wen;
          w = tl ? lsu_addr : ifu_addr;
          resp_data = in_rng(w) ? mm[wkey(w)] : 32'h0;
          if (resp_wen && in_rng(w)) begin
            for (int b = 0; b < 4; b++)
              if (lsu_wmask[b]) resp_data[8*b +: 8] = lsu_wdata[8*b +: 8];
            mm[wkey(w)] = resp_data;
          end
          sched = 1;
          acc_c = c;
          resp_c = c + L;
        end else begin
          sched = 0;
        end
      end
      tick();
    end
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    tbl[0]  = '{1'b1, 1'b1, B + 32'h0000, 32'h0010_0093, 4'hF, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, B + 32'h0010, 32'h1122_3344, 4'hF, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, B + 32'h0010, 32'hAABB_CCDD, 4'h5, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, B + 32'h0010, 32'h0,         4'h0, 32'h11BB_33DD};
    tbl[4]  = '{1'b0, 1'b0, B + 32'h0012, 32'h0,         4'h0, 32'h11BB_33DD};
    tbl[5]  = '{1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0,        4'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, B + 32'h4000, 32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, B + 32'h0000, 32'h0,         4'h0, 32'h0010_0093};
    tbl[8]  = '{1'b1, 1'b0, B + 32'h4000, 32'h0,         4'h0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, B + 32'h3FFC, 32'hCAFE_F00D, 4'hF, 32'h0};
    tbl[10] = '{1'b0, 1'b0, B + 32'h3FFC, 32'h0,         4'h0, 32'hCAFE_F00D};
    tbl[11] = '{1'b1, 1'b1, B + 32'h0010, 32'hFFFF_FFFF, 4'h0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, B + 32'h0010, 32'h0,         4'h0, 32'h11BB_33DD};
    tbl[13] = '{1'b1, 1'b1, B + 32'h3FFC, 32'h0000_0012, 4'h8, 32'h0};
    tbl[14] = '{1'b1, 1'b0, B + 32'h3FFF, 32'h0,         4'h0, 32'h00FE_F00D};
    tbl[15] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'h0};

    // Reset values.
    repeat (3) tick();
    chk("reset ifu_respValid", 32'(ifu_respValid), 32'd0);
    chk("reset lsu_respValid", 32'(lsu_respValid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ifu_rdata", ifu_rdata, 32'h0);
    chk("reset lsu_rdata", lsu_rdata, 32'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      xact(tbl[i].is_lsu, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
           tbl[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Reset clears rdata but not the array; fetch right after release.
    reset = 1'b0;
    repeat (2) tick();
    chk("rst2 ifu_rdata", ifu_rdata, 32'h0);
    chk("rst2 lsu_rdata", lsu_rdata, 32'h0);
    exp_ifu_rd = 32'h0;
    exp_lsu_rd = 32'h0;
    reset = 1'b1;
    xact(1'b0, 1'b0, B, 32'h0, 4'h0, 32'h0010_0093, "rst_fetch");

    // Arbitration and back-to-back.
    run_pair(0, 0, B, B + 32'h10, 32'h0010_0093, 32'h11BB_33DD, 4, 2, "same_cycle");
    run_pair(0, 2, B + 32'h3FFC, B, 32'h00FE_F00D, 32'h0010_0093, 2, 4, "ifu_then_lsu");
    run_pair(2, 0, B + 32'h10, B + 32'h3FFC, 32'h11BB_33DD, 32'h00FE_F00D, 4, 2,
             "lsu_then_ifu");
    run_pair(1, 0, B, B + 32'h10, 32'h0010_0093, 32'h11BB_33DD, 4, 2, "ifu_in_wait");
    run_pair(0, 1, B + 32'h10, B, 32'h11BB_33DD, 32'h0010_0093, 2, 4, "lsu_in_wait");

    // Reset during WAIT of a store aborts it.
    xact(1'b1, 1'b1, B + 32'h20, 32'h5A5A_5A5A, 4'hF, 32'h0, "pre_abort");
    lsu_reqValid = 1'b1;
    lsu_wen      = 1'b1;
    lsu_addr     = B + 32'h20;
    lsu_wdata    = 32'h1234_5678;
    lsu_wmask    = 4'hF;
    tick();
    chk("abort busy_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort busy_now", 32'(busy), 32'd0);
    chk("abort lsu_rdata", lsu_rdata, 32'h0);
    lsu_reqValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort no_resp", 32'(lsu_respValid), 32'd0);
      tick();
    end
    exp_ifu_rd = 32'h0;
    exp_lsu_rd = 32'h0;
    reset = 1'b1;
    tick();
    xact(1'b1, 1'b0, B + 32'h20, 32'h0, 4'h0, 32'h5A5A_5A5A, "abort_readback");

    random_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
